// File: rtl/time_counter_bank_if.sv
// Control and observation bundle for time_counter_bank: per-field up/down steps in,
// registered binary counts, BCD views and wrap-up indications out.
interface time_counter_bank_if;
    logic        i_ms_up;
    logic        i_ms_down;
    logic        i_sec_up;
    logic        i_sec_down;
    logic        i_min_up;
    logic        i_min_down;
    logic        i_hr_up;
    logic        i_hr_down;

    logic [9:0]  o_ms;
    logic [5:0]  o_sec;
    logic [5:0]  o_min;
    logic [4:0]  o_hr;

    logic [11:0] o_ms_bcd;
    logic [7:0]  o_sec_bcd;
    logic [7:0]  o_min_bcd;
    logic [7:0]  o_hr_bcd;

    logic        o_ms_carryup;
    logic        o_sec_carryup;
    logic        o_min_carryup;
    logic        o_hr_carryup;

    modport master (
        output i_ms_up, i_ms_down, i_sec_up, i_sec_down,
        output i_min_up, i_min_down, i_hr_up, i_hr_down,
        input  o_ms, o_sec, o_min, o_hr,
        input  o_ms_bcd, o_sec_bcd, o_min_bcd, o_hr_bcd,
        input  o_ms_carryup, o_sec_carryup, o_min_carryup, o_hr_carryup
    );

    modport slave (
        input  i_ms_up, i_ms_down, i_sec_up, i_sec_down,
        input  i_min_up, i_min_down, i_hr_up, i_hr_down,
        output o_ms, o_sec, o_min, o_hr,
        output o_ms_bcd, o_sec_bcd, o_min_bcd, o_hr_bcd,
        output o_ms_carryup, o_sec_carryup, o_min_carryup, o_hr_carryup
    );
endinterface

// File: rtl/time_counter_bank.sv
// Four independent wrap-around counters (ms/sec/min/hr) with up/down/clear control,
// combinational wrap-up flags for external cascading, and BCD views of each count.
module time_counter_bank #(
    parameter int P_MS_MAX  = 999,
    parameter int P_SEC_MAX = 59,
    parameter int P_MIN_MAX = 59,
    parameter int P_HR_MAX  = 23
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    time_counter_bank_if.slave   io_bus
);

    localparam logic [9:0] MS_MAX  = 10'(P_MS_MAX);
    localparam logic [5:0] SEC_MAX = 6'(P_SEC_MAX);
    localparam logic [5:0] MIN_MAX = 6'(P_MIN_MAX);
    localparam logic [4:0] HR_MAX  = 5'(P_HR_MAX);

    logic [9:0] r_ms;
    logic [5:0] r_sec;
    logic [5:0] r_min;
    logic [4:0] r_hr;

    function automatic logic [7:0] f_bcd2(input logic [5:0] v);
        return {4'(v / 6'd10), 4'(v % 6'd10)};
    endfunction

    function automatic logic [11:0] f_bcd3(input logic [9:0] v);
        return {4'(v / 10'd100), 4'((v / 10'd10) % 10'd10), 4'(v % 10'd10)};
    endfunction

    // Wrap tests use >= so a corrupted count above the terminal still returns to 0.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ms <= '0;
        end else if (io_bus.i_ms_up && io_bus.i_ms_down) begin
            r_ms <= '0;
        end else if (io_bus.i_ms_up) begin
            r_ms <= (r_ms >= MS_MAX) ? 10'd0 : r_ms + 10'd1;
        end else if (io_bus.i_ms_down) begin
            r_ms <= (r_ms == 10'd0 || r_ms > MS_MAX) ? MS_MAX : r_ms - 10'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sec <= '0;
        end else if (io_bus.i_sec_up && io_bus.i_sec_down) begin
            r_sec <= '0;
        end else if (io_bus.i_sec_up) begin
            r_sec <= (r_sec >= SEC_MAX) ? 6'd0 : r_sec + 6'd1;
        end else if (io_bus.i_sec_down) begin
            r_sec <= (r_sec == 6'd0 || r_sec > SEC_MAX) ? SEC_MAX : r_sec - 6'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_min <= '0;
        end else if (io_bus.i_min_up && io_bus.i_min_down) begin
            r_min <= '0;
        end else if (io_bus.i_min_up) begin
            r_min <= (r_min >= MIN_MAX) ? 6'd0 : r_min + 6'd1;
        end else if (io_bus.i_min_down) begin
            r_min <= (r_min == 6'd0 || r_min > MIN_MAX) ? MIN_MAX : r_min - 6'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hr <= '0;
        end else if (io_bus.i_hr_up && io_bus.i_hr_down) begin
            r_hr <= '0;
        end else if (io_bus.i_hr_up) begin
            r_hr <= (r_hr >= HR_MAX) ? 5'd0 : r_hr + 5'd1;
        end else if (io_bus.i_hr_down) begin
            r_hr <= (r_hr == 5'd0 || r_hr > HR_MAX) ? HR_MAX : r_hr - 5'd1;
        end
    end

    assign io_bus.o_ms  = r_ms;
    assign io_bus.o_sec = r_sec;
    assign io_bus.o_min = r_min;
    assign io_bus.o_hr  = r_hr;

    // Carry depends only on this field's own controls, so an external chain never loops.
    assign io_bus.o_ms_carryup  = ~i_rst & io_bus.i_ms_up  & ~io_bus.i_ms_down  & (r_ms  == MS_MAX);
    assign io_bus.o_sec_carryup = ~i_rst & io_bus.i_sec_up & ~io_bus.i_sec_down & (r_sec == SEC_MAX);
    assign io_bus.o_min_carryup = ~i_rst & io_bus.i_min_up & ~io_bus.i_min_down & (r_min == MIN_MAX);
    assign io_bus.o_hr_carryup  = ~i_rst & io_bus.i_hr_up  & ~io_bus.i_hr_down  & (r_hr  == HR_MAX);

    assign io_bus.o_ms_bcd  = f_bcd3(r_ms);
    assign io_bus.o_sec_bcd = f_bcd2(r_sec);
    assign io_bus.o_min_bcd = f_bcd2(r_min);
    assign io_bus.o_hr_bcd  = f_bcd2({1'b0, r_hr});

endmodule

// File: doc/time_counter_bank.md
TIME_COUNTER_BANK -- requirements
Module: time_counter_bank

Interface
REQ-001 Parameter P_MS_MAX, default 999, SHALL set the terminal value of the millisecond field (legal 1..999).
REQ-002 Parameter P_SEC_MAX, default 59, SHALL set the terminal value of the seconds field (legal 1..63).
REQ-003 Parameter P_MIN_MAX, default 59, SHALL set the terminal value of the minutes field (legal 1..63).
REQ-004 Parameter P_HR_MAX, default 23, SHALL set the terminal value of the hours field (legal 1..31).
REQ-005 i_clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 i_rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-007 i_ms_up, i_ms_down  input  1 each  SHALL be the millisecond field step/clear controls.
REQ-008 i_sec_up, i_sec_down  input  1 each  SHALL be the seconds field step/clear controls.
REQ-009 i_min_up, i_min_down  input  1 each  SHALL be the minutes field step/clear controls.
REQ-010 i_hr_up, i_hr_down  input  1 each  SHALL be the hours field step/clear controls.
REQ-011 o_ms  output  10, o_sec  output  6, o_min  output  6, o_hr  output  5  SHALL be the registered binary field counts.
REQ-012 o_ms_bcd  output  12, o_sec_bcd  output  8, o_min_bcd  output  8, o_hr_bcd  output  8  SHALL be BCD digits of each count, most significant digit in the high nibble.
REQ-013 o_ms_carryup, o_sec_carryup, o_min_carryup, o_hr_carryup  output  1 each  SHALL be the per-field wrap-up indications.

Function
REQ-014 Each field SHALL take exactly one action per cycle from its own up/down pair: up=1,down=0 -> increment; up=0,down=1 -> decrement; up=1,down=1 -> clear to 0; up=0,down=0 -> hold.
REQ-015 Increment at the field's P_*_MAX SHALL wrap to 0; otherwise count+1.
REQ-016 Decrement at 0 SHALL wrap to P_*_MAX; otherwise count-1.
REQ-017 A field's carryup SHALL be combinational: asserted iff that field's up=1, down=0 and count==P_*_MAX in the same cycle, and i_rst=0.
REQ-018 Decrement wrap SHALL produce no borrow output and SHALL NOT affect any other field.
REQ-019 Clear (up&down) at P_*_MAX SHALL NOT assert carryup.
REQ-020 Fields SHALL be independent; cascading is done externally by feeding o_X_carryup into the next field's up input in the same cycle, so a field wrap and the next field's increment land on the same clock edge.
REQ-021 The block SHALL contain no combinational path from any carryup output back to any up/down input.
REQ-022 Fields SHALL update in parallel on the same edge; simultaneous actions on several fields SHALL all take effect.
REQ-023 BCD outputs SHALL be combinational from the registered counts: o_ms_bcd = hundreds/tens/ones; the others tens/ones.
REQ-024 Counts SHALL never leave 0..P_*_MAX; unused count encodings SHALL NOT be reachable.
REQ-025 Latency: a count change SHALL be visible on o_* one cycle after the sampling edge; carryup SHALL be visible in the same cycle as the qualifying inputs.

Reset
REQ-026 With i_rst=1 at a rising edge, all four counts SHALL become 0 regardless of up/down inputs.
REQ-027 While i_rst=1 all carryup outputs SHALL be 0.
REQ-028 Reset asserted mid-cascade SHALL discard all pending increments; the first post-reset action SHALL occur on the first edge with i_rst=0.
REQ-029 After reset, BCD outputs SHALL read 0 (12'h000, 8'h00).

Verification
REQ-030 Counts 12:34:56.789, i_rst=1 for one edge -> all counts 0, all carryups 0 during reset, BCD all zero.
REQ-031 Carries looped (ms_carry->sec_up etc.), i_ms_up=1 steady from o_ms=998 -> cycle at 999 shows o_ms_carryup=1; next edge o_ms=0, o_sec incremented by 1.
REQ-032 Cascade from 23:59:59.999, one more ms_up cycle -> all four carryups=1 in that cycle; next edge 00:00:00.000; o_hr_carryup pulses exactly one cycle.
REQ-033 o_sec=0, i_sec_down=1 only -> o_sec=59, o_min unchanged, no carryup asserted.
REQ-034 o_ms=500 with i_ms_up=i_ms_down=1 -> o_ms=0 next edge; o_hr=23 with i_hr_up=i_hr_down=1 -> o_hr=0, o_hr_carryup=0.
REQ-035 o_hr=17, o_min=5, o_ms=42 -> o_hr_bcd=8'h17, o_min_bcd=8'h05, o_ms_bcd=12'h042.
